cfeb_push_seq: RTL and testbench

Readout push sequencer for the CFEB SCA/ADC data path. On a START request it produces the PUSH / LASTWORD / XLOAD / SENDCHECK control stream consumed directly by `blkcpld`, sitting immediately upstream of it. The stream consists of:

- NBLK data blocks of WORDS_PER_BLK pushes, each followed by an inter-block gap;
- a LASTWORD window;
- an optional extra-load (XLOAD) burst.

SENDCHECK is derived internally from PUSH/XLOAD with the fixed delay profile `blkcpld` expects.

---
 rtl/cfeb_push_pkg.sv | 25 ++
 rtl/cfeb_sendchk_gen.sv | 36 +++
 rtl/cfeb_push_seq.sv | 143 ++++++++++++++
 tb/tb_cfeb_push_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfeb_push_pkg.sv
// Shared types and defaults for the CFEB readout push sequencer.
// States, default timing constants and counter widths.
package cfeb_push_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLK    = 3'd1,
        GAP    = 3'd2,
        LAST   = 3'd3,
        POST   = 3'd4,
        XBURST = 3'd5,
        XGAP   = 3'd6
    } state_t;

    localparam int WORDS_PER_BLK_D = 96;
    localparam int GAP_LEN_D       = 6;
    localparam int CHK_DLY_D       = 6;
    localparam int CHK_LAG_D       = 3;

    localparam int WCNT_W = 7;
    localparam int GCNT_W = 3;
    localparam int BCNT_W = 4;
    localparam int XCNT_W = 6;

endpackage

// File: rtl/cfeb_sendchk_gen.sv
// SENDCHECK strobe: delayed data-push history gated by the push falling,
// then a fixed output lag. Extra-load pushes never feed the history.
module cfeb_sendchk_gen
    import cfeb_push_pkg::*;
#(
    parameter int CHK_DLY = CHK_DLY_D,
    parameter int CHK_LAG = CHK_LAG_D
) (
    input  logic CLK,
    input  logic RST_B,
    input  logic PUSH,
    input  logic XLOAD,
    output logic SENDCHECK
);

    logic [CHK_DLY-1:0] dly_q;
    logic [CHK_LAG-1:0] lag_q;
    logic               pre;
    logic               tr;

    assign pre = PUSH & ~XLOAD;
    assign tr  = ~PUSH & dly_q[CHK_DLY-1];

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            dly_q <= '0;
            lag_q <= '0;
        end else begin
            dly_q <= CHK_DLY'({dly_q, pre});
            lag_q <= CHK_LAG'({lag_q, tr});
        end
    end

    assign SENDCHECK = lag_q[CHK_LAG-1];

endmodule

// File: rtl/cfeb_push_seq.sv
// Readout push sequencer feeding blkcpld: data blocks, LASTWORD, XLOAD burst.
// Define PUSH_SEQ_XLOAD_EN to build the XLOAD burst states.
module cfeb_push_seq
    import cfeb_push_pkg::*;
#(
    parameter int WORDS_PER_BLK = WORDS_PER_BLK_D,
    parameter int GAP_LEN       = GAP_LEN_D,
    parameter int CHK_DLY       = CHK_DLY_D,
    parameter int CHK_LAG       = CHK_LAG_D
) (
    input  logic              CLK,
    input  logic              RST_B,
    input  logic              START,
    input  logic [BCNT_W-1:0] NBLK,
    input  logic [XCNT_W-1:0] XLEN,
    output logic              PUSH,
    output logic              XLOAD,
    output logic              LASTWORD,
    output logic              SENDCHECK,
    output logic              BUSY,
    output logic              DONE
);

    state_t state;
    state_t state_nxt;

    logic [WCNT_W-1:0] wcnt;
    logic [GCNT_W-1:0] gcnt;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] nblk_q;

    logic w_end, g_end, b_last, gap_st, accept;
    logic push_d, xload_d, last_d, busy_d, done_d;

    assign w_end  = wcnt == WCNT_W'(WORDS_PER_BLK - 1);
    assign g_end  = gcnt == GCNT_W'(GAP_LEN - 1);
    assign b_last = bcnt == nblk_q - BCNT_W'(1);
    assign accept = (state == IDLE) && START && (NBLK != '0);
    assign gap_st = (state == GAP) || (state == LAST) ||
                    (state == POST) || (state == XGAP);

`ifdef PUSH_SEQ_XLOAD_EN
    logic [XCNT_W-1:0] xcnt;
    logic [XCNT_W-1:0] xlen_q;
    logic              x_end;

    assign x_end = xcnt == xlen_q - XCNT_W'(1);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            xcnt   <= '0;
            xlen_q <= '0;
        end else begin
            xcnt <= (state == XBURST && state_nxt == XBURST) ?
                    xcnt + 1'b1 : '0;
            if (accept)
                xlen_q <= XLEN;
        end
    end
`else
    logic unused_xlen;
    assign unused_xlen = ^XLEN;
`endif

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state    <= IDLE;
            PUSH     <= 1'b0;
            XLOAD    <= 1'b0;
            LASTWORD <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_nxt;
            PUSH     <= push_d;
            XLOAD    <= xload_d;
            LASTWORD <= last_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = BLK;
            BLK:  if (w_end) state_nxt = GAP;
            GAP:  if (g_end) state_nxt = b_last ? LAST : BLK;
            LAST: if (g_end) state_nxt = POST;
`ifdef PUSH_SEQ_XLOAD_EN
            POST:   if (g_end) state_nxt = (xlen_q != '0) ? XBURST : IDLE;
            XBURST: if (x_end) state_nxt = XGAP;
            XGAP:   if (g_end) state_nxt = IDLE;
`else
            POST:   if (g_end) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with it.
    always_comb begin
        push_d  = (state_nxt == BLK) || (state_nxt == XBURST);
`ifdef PUSH_SEQ_XLOAD_EN
        xload_d = state_nxt == XBURST;
`else
        xload_d = 1'b0;
`endif
        last_d  = state_nxt == LAST;
        busy_d  = state_nxt != IDLE;
        done_d  = (state != IDLE) && (state_nxt == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wcnt   <= '0;
            gcnt   <= '0;
            bcnt   <= '0;
            nblk_q <= '0;
        end else begin
            wcnt <= (state == BLK && state_nxt == BLK) ? wcnt + 1'b1 : '0;
            gcnt <= (gap_st && state_nxt == state) ? gcnt + 1'b1 : '0;
            if (state == IDLE)
                bcnt <= '0;
            else if (state == GAP && g_end)
                bcnt <= bcnt + 1'b1;
            if (accept)
                nblk_q <= NBLK;
        end
    end

    cfeb_sendchk_gen #(
        .CHK_DLY(CHK_DLY),
        .CHK_LAG(CHK_LAG)
    ) u_chk (
        .CLK      (CLK),
        .RST_B    (RST_B),
        .PUSH     (PUSH),
        .XLOAD    (XLOAD),
        .SENDCHECK(SENDCHECK)
    );

endmodule

// File: tb/tb_cfeb_push_seq.sv
// Bench for cfeb_push_seq: sequence-level model plus directed scenarios.
// Honours PUSH_SEQ_XLOAD_EN the same way as the design.
module tb_cfeb_push_seq;

    localparam int W   = 96;
    localparam int G   = 6;
    localparam int LAG = 3;
    localparam int NSC = 6;
`ifdef PUSH_SEQ_XLOAD_EN
    localparam bit XEN = 1'b1;
`else
    localparam bit XEN = 1'b0;
`endif

    logic       CLK;
    logic       RST_B;
    logic       START;
    logic [3:0] NBLK;
    logic [5:0] XLEN;
    logic       PUSH, XLOAD, LASTWORD, SENDCHECK, BUSY, DONE;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    cfeb_push_seq dut (
        .CLK      (CLK),
        .RST_B    (RST_B),
        .START    (START),
        .NBLK     (NBLK),
        .XLEN     (XLEN),
        .PUSH     (PUSH),
        .XLOAD    (XLOAD),
        .LASTWORD (LASTWORD),
        .SENDCHECK(SENDCHECK),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sequence model: position k within an accepted sequence.
    bit m_act  = 0;
    bit m_done = 0;
    int m_k    = 0;
    int m_nb   = 0;
    int m_xl   = 0;
    int m_tot  = 0;

    always @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_act) begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_tot) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (START && NBLK != 4'd0) begin
                m_act <= 1'b1;
                m_k   <= 0;
                m_nb  <= int'(NBLK);
                m_xl  <= XEN ? int'(XLEN) : 0;
                m_tot <= int'(NBLK) * (W + G) + 2 * G +
                         ((XEN && XLEN != 6'd0) ? int'(XLEN) + G : 0);
            end
        end
    end

    function automatic logic [5:0] model_out();
        int   k, blk_end, r, q;
        logic p, x, l, s;
        p = 0; x = 0; l = 0; s = 0;
        if (m_act) begin
            k       = m_k;
            blk_end = m_nb * (W + G);
            if (k < blk_end) begin
                p = (k % (W + G)) < W;
            end else begin
                r = k - blk_end;
                if (r < G) l = 1;
                else if (r >= 2 * G && r < 2 * G + m_xl) begin
                    p = 1; x = 1;
                end
            end
            q = k - W - LAG;
            if (q >= 0 && q / (W + G) < m_nb && q % (W + G) < NSC) s = 1;
        end
        return {p, x, l, s, m_act, m_done};
    endfunction

    initial begin
        logic [5:0] got, exp;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                got = {PUSH, XLOAD, LASTWORD, SENDCHECK, BUSY, DONE};
                exp = model_out();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL cycle_cmp t=%0t got=%b want=%b (P X L S B D)",
                             $time, got, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after the DONE edge.
    task automatic run_seq(input logic [3:0] nb, input logic [5:0] xl,
                           input bit mid, input int e_len, input int e_push,
                           input int e_xl, input int e_sc, input int e_lw,
                           input string nm);
        int n, pc, xc, sc, lc;
        bit seen;
        n = 0; pc = 0; xc = 0; sc = 0; lc = 0; seen = 0;
        START = 1'b1; NBLK = nb; XLEN = xl;
        step(1);
        START = 1'b0;
        NBLK  = 4'($urandom_range(1, 15));
        XLEN  = 6'($urandom);
        chk({nm, "_start_lat"}, int'({PUSH, BUSY}), 3);
        while (n < 2000 && !seen) begin
            if (DONE) begin
                seen = 1;
            end else begin
                pc += int'(PUSH);
                xc += int'(XLOAD);
                sc += int'(SENDCHECK);
                lc += int'(LASTWORD);
                START = (mid && n == 50);
                if (mid && n == 50) begin
                    NBLK = 4'd15; XLEN = 6'd63;
                end
                step(1);
                n++;
            end
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_len"}, n, e_len);
        chk({nm, "_push_cnt"}, pc, e_push);
        chk({nm, "_xload_cnt"}, xc, e_xl);
        chk({nm, "_sendchk_cnt"}, sc, e_sc);
        chk({nm, "_lastword_cnt"}, lc, e_lw);
    endtask

    initial begin
        int acc;
        RST_B = 1'b0; START = 1'b0; NBLK = 4'd0; XLEN = 6'd0;
        step(3);
        chk("reset_outs",
            int'({PUSH, XLOAD, LASTWORD, SENDCHECK, BUSY, DONE}), 0);
        chk_en = 1;
        RST_B  = 1'b1;
        step(2);

        run_seq(4'd4, 6'd0, 0, 420, 384, 0, 24, 6, "nblk4");
        step(3);
        run_seq(4'd1, 6'd18, 0, XEN ? 138 : 114, XEN ? 114 : 96,
                XEN ? 18 : 0, 6, 6, "xlen18");
        step(3);

        START = 1'b1; NBLK = 4'd0; XLEN = 6'd5;
        step(1);
        START = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            acc += int'(BUSY | PUSH | DONE | SENDCHECK);
            step(1);
        end
        chk("nblk0_quiet", acc, 0);

        run_seq(4'd2, 6'd0, 1, 216, 192, 0, 12, 6, "start_busy");
        step(2);
        run_seq(4'd2, 6'd48, 0, XEN ? 270 : 216, XEN ? 240 : 192,
                XEN ? 48 : 0, 12, 6, "xlen48");

        run_seq(4'd1, 6'd0, 0, 114, 96, 0, 6, 6, "b2b_a");
        run_seq(4'd1, 6'd0, 0, 114, 96, 0, 6, 6, "b2b_b");
        step(2);

        START = 1'b1; NBLK = 4'd4; XLEN = 6'd0;
        step(1);
        START = 1'b0;
        step(120);
        chk("rst_pre_push", int'(PUSH), 1);
        RST_B = 1'b0;
        #1;
        chk("rst_mid_outs",
            int'({PUSH, XLOAD, LASTWORD, SENDCHECK, BUSY, DONE}), 0);
        step(2);
        RST_B = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            acc += int'(SENDCHECK | BUSY | PUSH);
            step(1);
        end
        chk("rst_after_quiet", acc, 0);
        run_seq(4'd1, 6'd0, 0, 114, 96, 0, 6, 6, "post_rst");
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
